shift_sequencer: RTL and testbench
==================================

# shift_sequencer

Multi-cycle controller that sequences a single shared 32-bit barrel shifter core to execute SHR, SHRA, SHL, ROR and ROL for the CPU datapath. It accepts one operation at a time over a valid/ready handshake, drives the shifter for one pass (shifts) or two passes (rotates), and holds the registered result until the consumer accepts it. It sits between the ALU operation decode and the C-register write path.

## Interface
- `WIDTH`, 32: datapath width. Fixed at 32; the shift amount is `b[4:0]`.
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  sequencer can accept a request this cycle.
- `op`  in  3  3'b000 SHR, 3'b001 SHRA, 3'b010 SHL, 3'b011 ROR, 3'b100 ROL; other codes are illegal.
- `a`  in  32  value to shift.
- `b`  in  32  shift amount; only `b[4:0]` is used and bits 31:5 are ignored.
- `out_valid`  out  1  `result` and `illegal` are valid.
- `out_ready`  in  1  consumer accepts the result.
- `result`  out  32  shifted or rotated value.
- `illegal`  out  1  the completed request had an illegal `op`.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, PASS1, PASS2, DONE.
- Handshake:
  - `in_ready` = (state == IDLE) || (state == DONE && `out_ready`).
  - A request is accepted on a cycle where `in_valid` && `in_ready`.
  - On accept, `op`, `a` and `n = b[4:0]` are latched and the state goes to PASS1.
- PASS1 drives the shifter with the latched `a`:
  - SHR, SHRA and SHL use amount `n`. The shifter output is registered into `result`, then the state goes to DONE.
  - ROR shifts right logically by `n`. ROL shifts left by `n`. The output goes into partial register `p`, then the state goes to PASS2.
  - For an illegal op, `result` is set to `a`, `illegal` is set to 1, and the state goes to DONE with no shifter use.
- PASS2 (rotates only):
  - The shift amount is `m = (0 - n) mod 32`, a 5-bit wrap.
  - ROR shifts `a` left by `m`. ROL shifts `a` right logically by `m`.
  - `result` = `p` | shifter output, then the state goes to DONE.
  - When n = 0, m = 0 and `result` = `a`, which is correct with no special case.
- SHRA fills vacated bits with `a[31]` at every stage. SHR and SHL fill with zeros.
- DONE: `out_valid` = 1; `result` and `illegal` are held stable until `out_ready`.
  - `out_ready` without a new accept: go to IDLE.
  - `out_ready` with a new accept in the same cycle: go to PASS1 with the new operands.
- `illegal` is cleared on every accept.

## Timing
- Reset values: state IDLE, `in_ready` 1, `out_valid` 0, `busy` 0, `result` 32'h0, `illegal` 0, `p` 32'h0.
- Latency, counted from the accepting edge to the first cycle with `out_valid` high:
  - SHR, SHRA, SHL and illegal ops: 2 edges.
  - Rotates: 3 edges.
- Throughput with `out_ready` held high:
  - One shift every 2 cycles.
  - One rotate every 3 cycles.
- Reset asserted in any state:
  - Returns to IDLE on that edge and drops `out_valid`.
  - The in-flight operation is discarded and no result is produced.
- Reset has priority over a simultaneous accept.
- `in_valid` while not ready has no effect. Inputs need not be held after the accept.

## Configuration
- `SHIFT_SEQ_ROTATE_EN` defined:
  - ROR and ROL are implemented as above.
  - The PASS2 state and register `p` exist.
- `SHIFT_SEQ_ROTATE_EN` undefined:
  - Ops 3'b011 and 3'b100 are illegal: `result` = `a`, `illegal` = 1, latency 2.
  - The PASS2 state and `p` are removed.

## Structure
- Package `shift_pkg` holds:
  - the op encoding localparams (`OP_SHR`, `OP_SHRA`, `OP_SHL`, `OP_ROR`, `OP_ROL`);
  - the state encoding (`ST_IDLE`, `ST_PASS1`, `ST_PASS2`, `ST_DONE`).
- One sub-module, `shift_core`: a combinational 5-stage log shifter.
  - Inputs are `data[31:0]`, `amt[4:0]` and `mode[1:0]` (right-logical, right-arithmetic, left).
  - It is instantiated exactly once and is the only shifting logic in the block.

## Test plan
- SHR, `a` = 32'h8000_00F0, `b` = 4 -> 32'h0800_000F after 2 edges. SHRA with the same operands -> 32'hF800_000F.
- SHL, `a` = 32'h0000_0001, `b` = 32'h0000_003F (upper bits ignored, n = 31) -> 32'h8000_0000. `illegal` = 0.
- ROR, `a` = 32'h1234_5678, `b` = 8 -> 32'h7812_3456 after 3 edges. ROL by 0 -> 32'h1234_5678.
- `op` = 3'b111 -> `result` = `a`, `illegal` = 1. With `SHIFT_SEQ_ROTATE_EN` undefined, ROR by 8 -> `result` = `a`, `illegal` = 1, latency 2.
- Back-pressure: hold `out_ready` low for 5 cycles in DONE -> `result` stable and `in_ready` 0. Then `out_ready` and `in_valid` both high -> new op accepted in that cycle with no IDLE bubble.
- Reset pulsed during PASS2 -> next cycle IDLE, `out_valid` 0, `result` 0; the following SHL by 1 of 32'h1 -> 32'h2.

Source files
------------

// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_pkg
// Purpose  : Shared encodings for the shift sequencer: operation codes,
//            controller state encoding and shifter core modes, plus the
//            legality decode for an operation code.
// Config   : SHIFT_SEQ_ROTATE_EN - when defined, ROR/ROL are legal ops.
// Revision : 1.0 - initial release
// ============================================================================
package shift_pkg;

    // Operation codes presented on op
    localparam logic [2:0] OP_SHR  = 3'b000;
    localparam logic [2:0] OP_SHRA = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_ROR  = 3'b011;
    localparam logic [2:0] OP_ROL  = 3'b100;

    // Controller state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PASS1 = 2'd1;
    localparam logic [1:0] ST_PASS2 = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Shifter core modes
    localparam logic [1:0] MODE_RL = 2'd0;  // right, zero fill
    localparam logic [1:0] MODE_RA = 2'd1;  // right, sign fill
    localparam logic [1:0] MODE_SL = 2'd2;  // left, zero fill

    // Rotates are only legal when the two-pass rotate path is built.
    function automatic logic op_legal(input logic [2:0] op);
`ifdef SHIFT_SEQ_ROTATE_EN
        return (op <= OP_ROL);
`else
        return (op <= OP_SHL);
`endif
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_core.sv
`default_nettype none
// ============================================================================
// Module   : shift_core
// Purpose  : Combinational 5-stage logarithmic barrel shifter, 32 bits.
//            Stage k shifts by 2**k when amt[k] is set.
// Ports    : data    in  32  value to shift
//            amt     in  5   shift amount
//            mode    in  2   MODE_RL / MODE_RA / MODE_SL
//            shifted out 32  shifted value
// Revision : 1.0 - initial release
// ============================================================================
module shift_core
    import shift_pkg::*;
(
    input  logic [31:0] data,
    input  logic [4:0]  amt,
    input  logic [1:0]  mode,
    output logic [31:0] shifted
);

    logic [5:0][31:0] w_stage;
    logic             w_fill;
    logic             w_left;

    // Arithmetic right shifts fill every stage with the original sign bit.
    assign w_fill     = (mode == MODE_RA) & data[31];
    assign w_left     = (mode == MODE_SL);
    assign w_stage[0] = data;

    for (genvar k = 0; k < 5; k++) begin : g_stage
        localparam int SH = 1 << k;
        logic [31:0] w_right_val;
        logic [31:0] w_left_val;

        assign w_right_val = {{SH{w_fill}}, w_stage[k][31:SH]};
        assign w_left_val  = {w_stage[k][31-SH:0], {SH{1'b0}}};

        assign w_stage[k+1] = !amt[k] ? w_stage[k]  :
                              w_left  ? w_left_val  : w_right_val;
    end

    assign shifted = w_stage[5];

endmodule
`default_nettype wire

// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : shift_sequencer
// Purpose  : Sequences one shared shift_core to execute SHR, SHRA, SHL (one
//            pass) and ROR, ROL (two passes, OR-combined) behind a
//            valid/ready handshake; the result is held until accepted.
// Config   : SHIFT_SEQ_ROTATE_EN - builds the PASS2 state and the partial
//            register; without it ROR/ROL complete as illegal ops.
// Ports    : clock, reset        clock / synchronous active-high reset
//            in_valid, in_ready  request handshake
//            op[2:0], a[31:0], b[31:0]  operation, value, amount (b[4:0])
//            out_valid, out_ready       result handshake
//            result[31:0], illegal      completed value / illegal-op flag
//            busy                       controller not idle
// Revision : 1.0 - initial release
// ============================================================================
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             illegal,
    output logic             busy
);

    logic [1:0]  r_state;
    logic [2:0]  r_op;
    logic [31:0] r_a;
    logic [4:0]  r_n;
    logic [31:0] r_result;
    logic        r_illegal;
`ifdef SHIFT_SEQ_ROTATE_EN
    logic [31:0] r_p;
    logic        w_pass2;
`endif

    logic        w_accept;
    logic [4:0]  w_amt;
    logic [1:0]  w_mode;
    logic [31:0] w_shifted;
    logic        w_unused_b;

    assign w_unused_b = ^b[31:5];   // upper amount bits are ignored

    assign in_ready  = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign result    = r_result;
    assign illegal   = r_illegal;

`ifdef SHIFT_SEQ_ROTATE_EN
    assign w_pass2 = (r_state == ST_PASS2);
`endif

    // Shifter control. Rotates shift one way by n, then the other way by
    // (32 - n) mod 32; n = 0 gives two zero-length shifts and result = a.
    always_comb begin
        w_amt  = r_n;
        w_mode = MODE_RL;
        case (r_op)
            OP_SHRA: w_mode = MODE_RA;
            OP_SHL:  w_mode = MODE_SL;
`ifdef SHIFT_SEQ_ROTATE_EN
            OP_ROR:  w_mode = w_pass2 ? MODE_SL : MODE_RL;
            OP_ROL:  w_mode = w_pass2 ? MODE_RL : MODE_SL;
`endif
            default: w_mode = MODE_RL;
        endcase
`ifdef SHIFT_SEQ_ROTATE_EN
        if (w_pass2) begin
            w_amt = 5'd0 - r_n;
        end
`endif
    end

    shift_core u_core (
        .data    (r_a),
        .amt     (w_amt),
        .mode    (w_mode),
        .shifted (w_shifted)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_op      <= OP_SHR;
            r_a       <= 32'h0;
            r_n       <= 5'd0;
            r_result  <= 32'h0;
            r_illegal <= 1'b0;
`ifdef SHIFT_SEQ_ROTATE_EN
            r_p       <= 32'h0;
`endif
        end else if (w_accept) begin
            // Accept from IDLE, or from DONE in the same cycle the result drains.
            r_op      <= op;
            r_a       <= a;
            r_n       <= b[4:0];
            r_illegal <= 1'b0;
            r_state   <= ST_PASS1;
        end else begin
            case (r_state)
                ST_IDLE: r_state <= ST_IDLE;
                ST_PASS1: begin
                    if (!op_legal(r_op)) begin
                        r_result  <= r_a;
                        r_illegal <= 1'b1;
                        r_state   <= ST_DONE;
                    end
`ifdef SHIFT_SEQ_ROTATE_EN
                    else if ((r_op == OP_ROR) || (r_op == OP_ROL)) begin
                        r_p     <= w_shifted;
                        r_state <= ST_PASS2;
                    end
`endif
                    else begin
                        r_result <= w_shifted;
                        r_state  <= ST_DONE;
                    end
                end
`ifdef SHIFT_SEQ_ROTATE_EN
                ST_PASS2: begin
                    r_result <= r_p | w_shifted;
                    r_state  <= ST_DONE;
                end
`endif
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_sequencer
// Purpose  : Self-checking bench for shift_sequencer: directed cases plus
//            randomized operations scored against an arithmetic model of
//            shifts and rotates. Honours SHIFT_SEQ_ROTATE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_sequencer;
    import shift_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        illegal;
    logic        busy;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] r_exp_res;
    logic [31:0] r_exp_ill;

    always #5 clock = ~clock;

    shift_sequencer #(.WIDTH(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .illegal   (illegal),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit model_legal(input logic [2:0] o);
`ifdef SHIFT_SEQ_ROTATE_EN
        return (o <= 3'd4);
`else
        return (o <= 3'd2);
`endif
    endfunction

    function automatic logic [31:0] model_result(input logic [2:0] o,
                                                 input logic [31:0] x,
                                                 input logic [31:0] y);
        int          n;
        logic [63:0] d;
        logic [63:0] t;
        logic [31:0] s;
        n = int'(y[4:0]);
        d = {x, x};
        if (!model_legal(o)) return x;
        case (o)
            3'd0: return x >> n;
            3'd1: begin s = $signed(x) >>> n; return s; end
            3'd2: return x << n;
            3'd3: begin t = d >> n; return t[31:0]; end
            default: begin t = d << n; return t[63:32]; end
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] o);
        if (model_legal(o) && (o >= 3'd3)) return 3;
        return 2;
    endfunction

    // Issue one op from IDLE or DONE (draining any pending result in the
    // same cycle) and wait for its completion.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        int cyc;
        op        = o;
        a         = x;
        b         = y;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check("in_ready_accept", 32'(in_ready), 32'd1);
        @(posedge clock); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a  = $urandom;
        b  = $urandom;
        op = 3'($urandom_range(0, 7));
        check("busy_pass1", 32'(busy), 32'd1);
        cyc = 1;
        while (!out_valid && cyc < 8) begin
            @(posedge clock); #1;
            cyc++;
        end
        r_exp_res = model_result(o, x, y);
        r_exp_ill = model_legal(o) ? 32'd0 : 32'd1;
        check("latency", 32'(cyc), 32'(model_lat(o)));
        check("result", result, r_exp_res);
        check("illegal", 32'(illegal), r_exp_ill);
        check("in_ready_bp", 32'(in_ready), 32'd0);
    endtask

    task automatic hold(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge clock); #1;
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_result", result, r_exp_res);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        check("drain_valid", 32'(out_valid), 32'd0);
        check("drain_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  ro;
        logic [31:0] rx;
        logic [31:0] ry;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op = 3'd0; a = 32'h0; b = 32'h0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_result", result, 32'h0);
        check("rst_illegal", 32'(illegal), 32'd0);

        // Directed cases
        issue(OP_SHR, 32'h8000_00F0, 32'd4);
        check("shr_dir", result, 32'h0800_000F);
        drain();
        issue(OP_SHRA, 32'h8000_00F0, 32'd4);
        check("shra_dir", result, 32'hF800_000F);
        drain();
        issue(OP_SHL, 32'h0000_0001, 32'h0000_003F);
        check("shl_dir", result, 32'h8000_0000);
        check("shl_dir_ill", 32'(illegal), 32'd0);
        drain();
        issue(OP_ROR, 32'h1234_5678, 32'd8);
`ifdef SHIFT_SEQ_ROTATE_EN
        check("ror_dir", result, 32'h7812_3456);
`else
        check("ror_dir", result, 32'h1234_5678);
        check("ror_dir_ill", 32'(illegal), 32'd1);
`endif
        drain();
        issue(OP_ROL, 32'h1234_5678, 32'd0);
        check("rol0_dir", result, 32'h1234_5678);
        drain();
        issue(3'b111, 32'hDEAD_BEEF, 32'd3);
        check("illegal_dir_res", result, 32'hDEAD_BEEF);
        check("illegal_dir_flag", 32'(illegal), 32'd1);

        // Back-pressure, then back-to-back accept with no IDLE bubble
        hold(5);
        issue(OP_SHL, 32'h0000_00FF, 32'd8);
        check("b2b_res", result, 32'h0000_FF00);
        check("b2b_ill_cleared", 32'(illegal), 32'd0);
        drain();

        // Reset takes priority over a simultaneous accept
        reset = 1'b1; in_valid = 1'b1; op = OP_SHL; a = 32'h1; b = 32'h1;
        @(posedge clock); #1;
        reset = 1'b0; in_valid = 1'b0;
        check("rst_prio_busy", 32'(busy), 32'd0);

        // Reset mid-operation (PASS2 when rotates are built)
        op = OP_ROR; a = 32'h1234_5678; b = 32'd8; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_result", result, 32'h0);
        check("midrst_busy", 32'(busy), 32'd0);
        issue(OP_SHL, 32'h1, 32'h1);
        check("after_rst_shl", result, 32'h2);
        drain();

        // Randomized operations with random back-pressure and chaining
        for (int i = 0; i < 60; i++) begin
            ro = 3'($urandom_range(0, 7));
            rx = $urandom;
            ry = $urandom;
            issue(ro, rx, ry);
            hold(int'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 1) drain();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
